// File: rtl/bram16_dma_pkg.sv
// Shared types and constants for the bram16_dma block-copy initiator.
package bram16_dma_pkg;

  localparam int unsigned BRAM16_WORD_W = 16;
  localparam int unsigned BRAM16_ADR_W  = 11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic [BRAM16_WORD_W-1:0] src;
    logic [BRAM16_WORD_W-1:0] dst;
    logic [BRAM16_WORD_W-1:0] len;
  } dma_req_t;

endpackage

// File: rtl/bram16_dma.sv
// Forward block copy over a 16-bit synchronous-read RAM port (RD/CAP/WR per word).
// Optional fill mode (fill, fill_val ports) is enabled by defining BRAM16_DMA_FILL_EN.
module bram16_dma
  import bram16_dma_pkg::*;
(
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     start,
  input  logic [BRAM16_WORD_W-1:0] src,
  input  logic [BRAM16_WORD_W-1:0] dst,
  input  logic [BRAM16_WORD_W-1:0] len,
`ifdef BRAM16_DMA_FILL_EN
  input  logic                     fill,
  input  logic [BRAM16_WORD_W-1:0] fill_val,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [BRAM16_WORD_W-1:0] a,
  output logic [BRAM16_WORD_W-1:0] dout,
  output logic                     we,
  input  logic [BRAM16_WORD_W-1:0] di
);

  localparam int unsigned W = BRAM16_WORD_W;

  state_e         state_q, state_d;
  dma_req_t       req_q, req_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   data_q, data_d;
  logic [W-1:0]   wr_val_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           we_q, we_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
`ifdef BRAM16_DMA_FILL_EN
  logic           fill_q, fill_d;
  logic [W-1:0]   fill_val_q, fill_val_d;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef BRAM16_DMA_FILL_EN
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          req_d = '{src: src, dst: dst, len: len};
          cnt_d = '0;
`ifdef BRAM16_DMA_FILL_EN
          fill_d     = fill;
          fill_val_d = fill_val;
          if (len == '0)  state_d = ST_DONE;
          else if (fill)  state_d = ST_WR;
          else            state_d = ST_RD;
`else
          state_d = (len == '0) ? ST_DONE : ST_RD;
`endif
        end
      end
      ST_RD:  state_d = ST_CAP;
      ST_CAP: begin
        data_d  = di;
        state_d = ST_WR;
      end
      ST_WR: begin
        cnt_d = cnt_q + W'(1);
`ifdef BRAM16_DMA_FILL_EN
        if (cnt_d == req_q.len) state_d = ST_DONE;
        else if (fill_q)        state_d = ST_WR;
        else                    state_d = ST_RD;
`else
        state_d = (cnt_d == req_q.len) ? ST_DONE : ST_RD;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef BRAM16_DMA_FILL_EN
  assign wr_val_d = fill_d ? fill_val_d : data_d;
`else
  assign wr_val_d = data_d;
`endif

  // Outputs are decoded from the next registered state so they line up with it.
  always_comb begin
    a_d    = '0;
    dout_d = '0;
    we_d   = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      ST_RD, ST_CAP: begin
        a_d    = req_d.src + cnt_d;
        busy_d = 1'b1;
      end
      ST_WR: begin
        a_d    = req_d.dst + cnt_d;
        dout_d = wr_val_d;
        we_d   = 1'b1;
        busy_d = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      a_q     <= '0;
      dout_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BRAM16_DMA_FILL_EN
      fill_q     <= 1'b0;
      fill_val_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BRAM16_DMA_FILL_EN
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
`endif
    end
  end

  assign a    = a_q;
  assign dout = dout_q;
  assign we   = we_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
